// File: rtl/vdp_cpu_port.sv
// Host-CPU port sequencer for the VDP bus: qualifies filtered /CSR and /CSW strobes by pulse
// width and emits registered write/read strobes and the CD output-driver controls.
module vdp_cpu_port #(
    parameter int unsigned MIN_LOW  = 3,
    parameter int unsigned RECOVERY = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       csr_n_f,
    input  logic       csw_n_f,
    input  logic       mode_f,
    input  logic [7:0] cd_in,
    input  logic [7:0] rd_data,
    output logic       wr_stb,
    output logic       wr_port,
    output logic [7:0] wr_data,
    output logic       rd_stb,
    output logic       rd_port,
    output logic       rd_done,
    output logic [7:0] cd_out,
    output logic       cd_oe,
    output logic       glitch,
    output logic       conflict
);

    typedef enum logic [2:0] {
        StIdle,
        StWrQual,
        StWrAct,
        StRdQual,
        StRdAct,
        StRecover
    } state_e;

    localparam logic [3:0] MinLow      = 4'(MIN_LOW);
    localparam logic [3:0] Recovery    = 4'(RECOVERY);
    localparam bit         QualOnFall  = (MIN_LOW <= 1);
    localparam state_e     AfterAccess = (RECOVERY == 0) ? StIdle : StRecover;

    state_e     state_q, state_d;
    logic [3:0] qcnt_q, qcnt_d, rcnt_q, rcnt_d;
    logic [3:0] qcnt_inc, rcnt_inc;
    logic       prev_r_q, prev_w_q, armed_q;
    logic       csr_lvl, csw_lvl, fall_r, fall_w;
    logic [7:0] hold_q, hold_d;
    logic       wport_q, wport_d, rport_q, rport_d;
    logic       wr_stb_q, wr_stb_d, rd_stb_q, rd_stb_d, rd_done_q, rd_done_d;
    logic       glitch_q, glitch_d, conflict_q, conflict_d;
    logic       wr_port_q, wr_port_d, rd_port_q, rd_port_d, cd_oe_q, cd_oe_d;
    logic [7:0] wr_data_q, wr_data_d, cd_out_q, cd_out_d;

    // An undriven (X/Z) filter output keeps the last resolved level.
    always_comb begin
        case (csr_n_f)
            1'b0:    csr_lvl = 1'b0;
            1'b1:    csr_lvl = 1'b1;
            default: csr_lvl = prev_r_q;
        endcase
        case (csw_n_f)
            1'b0:    csw_lvl = 1'b0;
            1'b1:    csw_lvl = 1'b1;
            default: csw_lvl = prev_w_q;
        endcase
    end

    // armed_q masks the first edge after reset so a strobe held low through reset is not a fall.
    assign fall_r   = armed_q & prev_r_q & ~csr_lvl;
    assign fall_w   = armed_q & prev_w_q & ~csw_lvl;
    assign qcnt_inc = (qcnt_q == 4'hf) ? qcnt_q : qcnt_q + 4'd1;
    assign rcnt_inc = (rcnt_q == 4'hf) ? rcnt_q : rcnt_q + 4'd1;

    always_comb begin
        state_d    = state_q;
        qcnt_d     = qcnt_q;
        rcnt_d     = rcnt_q;
        hold_d     = hold_q;
        wport_d    = wport_q;
        rport_d    = rport_q;
        wr_stb_d   = 1'b0;
        rd_stb_d   = 1'b0;
        rd_done_d  = 1'b0;
        glitch_d   = 1'b0;
        conflict_d = 1'b0;
        wr_port_d  = wr_port_q;
        wr_data_d  = wr_data_q;
        rd_port_d  = rd_port_q;
        cd_out_d   = cd_out_q;
        cd_oe_d    = cd_oe_q;
        unique case (state_q)
            StIdle: begin
                if (fall_w && csr_lvl) begin
                    qcnt_d  = 4'd1;
                    hold_d  = cd_in;
                    wport_d = mode_f;
                    state_d = QualOnFall ? StWrAct : StWrQual;
                end else if (fall_r && csw_lvl) begin
                    qcnt_d  = 4'd1;
                    rport_d = mode_f;
                    if (QualOnFall) begin
                        rd_stb_d  = 1'b1;
                        rd_port_d = mode_f;
                        cd_oe_d   = 1'b1;
                        state_d   = StRdAct;
                    end else begin
                        state_d = StRdQual;
                    end
                end else if ((fall_w || fall_r) && !csw_lvl && !csr_lvl) begin
                    conflict_d = 1'b1;
                end
            end
            StWrQual: begin
                conflict_d = fall_r;
                if (csw_lvl) begin
                    glitch_d = 1'b1;
                    state_d  = StIdle;
                end else begin
                    qcnt_d = qcnt_inc;
                    hold_d = cd_in;
                    if (qcnt_inc >= MinLow) state_d = StWrAct;
                end
            end
            StWrAct: begin
                conflict_d = fall_r;
                if (csw_lvl) begin
                    wr_stb_d  = 1'b1;
                    wr_data_d = hold_q;
                    wr_port_d = wport_q;
                    rcnt_d    = 4'd0;
                    state_d   = AfterAccess;
                end else begin
                    hold_d = cd_in;
                end
            end
            StRdQual: begin
                conflict_d = fall_w;
                if (csr_lvl) begin
                    glitch_d = 1'b1;
                    state_d  = StIdle;
                end else begin
                    qcnt_d = qcnt_inc;
                    if (qcnt_inc >= MinLow) begin
                        rd_stb_d  = 1'b1;
                        rd_port_d = rport_q;
                        cd_oe_d   = 1'b1;
                        state_d   = StRdAct;
                    end
                end
            end
            StRdAct: begin
                conflict_d = fall_w;
                cd_out_d   = rd_data;
                if (csr_lvl) begin
                    cd_oe_d   = 1'b0;
                    rd_done_d = 1'b1;
                    rcnt_d    = 4'd0;
                    state_d   = AfterAccess;
                end
            end
            StRecover: begin
                if (rcnt_inc >= Recovery) state_d = StIdle;
                else                      rcnt_d  = rcnt_inc;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            qcnt_q     <= 4'd0;
            rcnt_q     <= 4'd0;
            prev_r_q   <= 1'b1;
            prev_w_q   <= 1'b1;
            armed_q    <= 1'b0;
            hold_q     <= 8'h00;
            wport_q    <= 1'b0;
            rport_q    <= 1'b0;
            wr_stb_q   <= 1'b0;
            rd_stb_q   <= 1'b0;
            rd_done_q  <= 1'b0;
            glitch_q   <= 1'b0;
            conflict_q <= 1'b0;
            wr_port_q  <= 1'b0;
            wr_data_q  <= 8'h00;
            rd_port_q  <= 1'b0;
            cd_out_q   <= 8'h00;
            cd_oe_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            qcnt_q     <= qcnt_d;
            rcnt_q     <= rcnt_d;
            prev_r_q   <= csr_lvl;
            prev_w_q   <= csw_lvl;
            armed_q    <= 1'b1;
            hold_q     <= hold_d;
            wport_q    <= wport_d;
            rport_q    <= rport_d;
            wr_stb_q   <= wr_stb_d;
            rd_stb_q   <= rd_stb_d;
            rd_done_q  <= rd_done_d;
            glitch_q   <= glitch_d;
            conflict_q <= conflict_d;
            wr_port_q  <= wr_port_d;
            wr_data_q  <= wr_data_d;
            rd_port_q  <= rd_port_d;
            cd_out_q   <= cd_out_d;
            cd_oe_q    <= cd_oe_d;
        end
    end

    assign wr_stb   = wr_stb_q;
    assign wr_port  = wr_port_q;
    assign wr_data  = wr_data_q;
    assign rd_stb   = rd_stb_q;
    assign rd_port  = rd_port_q;
    assign rd_done  = rd_done_q;
    assign cd_out   = cd_out_q;
    assign cd_oe    = cd_oe_q;
    assign glitch   = glitch_q;
    assign conflict = conflict_q;

endmodule

// File: tb/tb_vdp_cpu_port.sv
// Bench for vdp_cpu_port: directed scenarios plus a randomized strobe stream checked against
// an edge-index model of pulse-width qualification and recovery.
module tb_vdp_cpu_port;

    localparam int unsigned MIN_LOW  = 3;
    localparam int unsigned RECOVERY = 2;
    localparam int          N        = 600;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       csr_n_f = 1'b1, csw_n_f = 1'b1, mode_f = 1'b0;
    logic [7:0] cd_in = 8'h00, rd_data = 8'h00;
    logic       wr_stb, wr_port, rd_stb, rd_port, rd_done, cd_oe, glitch, conflict;
    logic [7:0] wr_data, cd_out;

    int checks = 0, passed = 0;
    int n_wr, n_rd, n_done, n_glitch, n_conf;

    logic       ar_csr[N], ar_csw[N], ar_mode[N];
    logic [7:0] ar_cd[N], ar_rd[N];
    logic [5:0] ex_pulse[N];
    logic [7:0] ex_wdata[N], ex_cd[N];
    logic       ex_wport[N], ex_rport[N], ex_cd_valid[N];

    vdp_cpu_port #(.MIN_LOW(MIN_LOW), .RECOVERY(RECOVERY)) dut (
        .clk(clk), .reset_n(reset_n), .csr_n_f(csr_n_f), .csw_n_f(csw_n_f), .mode_f(mode_f),
        .cd_in(cd_in), .rd_data(rd_data), .wr_stb(wr_stb), .wr_port(wr_port),
        .wr_data(wr_data), .rd_stb(rd_stb), .rd_port(rd_port), .rd_done(rd_done),
        .cd_out(cd_out), .cd_oe(cd_oe), .glitch(glitch), .conflict(conflict)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        if (wr_stb)   n_wr++;
        if (rd_stb)   n_rd++;
        if (rd_done)  n_done++;
        if (glitch)   n_glitch++;
        if (conflict) n_conf++;
    endtask

    task automatic clear_counts();
        n_wr = 0; n_rd = 0; n_done = 0; n_glitch = 0; n_conf = 0;
    endtask

    task automatic idle(input int n);
        csr_n_f = 1'b1;
        csw_n_f = 1'b1;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #3;
        checks++;
        if ({wr_stb, rd_stb, rd_done, glitch, conflict, cd_oe, wr_port, rd_port} !== 8'h00)
            $display("FAIL reset_flags: got %b want 00000000",
                     {wr_stb, rd_stb, rd_done, glitch, conflict, cd_oe, wr_port, rd_port});
        else passed++;
        checks++;
        if (wr_data !== 8'h00) $display("FAIL reset_wr_data: got %h want 00", wr_data);
        else passed++;
        checks++;
        if (cd_out !== 8'h00) $display("FAIL reset_cd_out: got %h want 00", cd_out);
        else passed++;
        @(negedge clk);
        reset_n = 1'b1;
        idle(4);
    endtask

    task automatic test_write();
        clear_counts();
        mode_f = 1'b1;
        cd_in = 8'h12;
        csw_n_f = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (k == 5) cd_in = 8'hA5;
            tick();
        end
        csw_n_f = 1'b1;
        cd_in = 8'h00;
        mode_f = 1'b0;
        tick();
        checks++;
        if ({wr_stb, wr_port, wr_data} !== {1'b1, 1'b1, 8'hA5})
            $display("FAIL write_out: got stb=%b port=%b data=%h want 1 1 a5",
                     wr_stb, wr_port, wr_data);
        else passed++;
        idle(4);
        checks++;
        if (n_wr !== 1) $display("FAIL write_count: got %0d want 1", n_wr);
        else passed++;
    endtask

    task automatic test_glitch();
        clear_counts();
        csw_n_f = 1'b0;
        tick();
        tick();
        csw_n_f = 1'b1;
        tick();
        checks++;
        if (glitch !== 1'b1) $display("FAIL glitch_pulse: got %b want 1", glitch);
        else passed++;
        idle(4);
        checks++;
        if ({n_wr, n_glitch} !== {32'd0, 32'd1})
            $display("FAIL glitch_counts: got wr=%0d glitch=%0d want 0 1", n_wr, n_glitch);
        else passed++;
    endtask

    task automatic test_read();
        clear_counts();
        rd_data = 8'h3C;
        mode_f = 1'b0;
        csr_n_f = 1'b0;
        for (int k = 0; k <= 8; k++) begin
            if (k == 8) csr_n_f = 1'b1;
            tick();
            if (k == 0) mode_f = 1'b1;
            checks++;
            if ({rd_stb, cd_oe, rd_done} !== {k == 2, k >= 2 && k < 8, k == 8})
                $display("FAIL read_flags_%0d: got stb/oe/done=%b%b%b want %b%b%b", k,
                         rd_stb, cd_oe, rd_done, k == 2, k >= 2 && k < 8, k == 8);
            else passed++;
            if (k >= 3 && k < 8) begin
                checks++;
                if (cd_out !== 8'h3C) $display("FAIL read_cd_out_%0d: got %h want 3c", k, cd_out);
                else passed++;
            end
            if (k == 2) begin
                checks++;
                if (rd_port !== 1'b0) $display("FAIL read_port: got %b want 0", rd_port);
                else passed++;
            end
        end
        idle(4);
        checks++;
        if ({n_rd, n_done} !== {32'd1, 32'd1})
            $display("FAIL read_counts: got rd=%0d done=%0d want 1 1", n_rd, n_done);
        else passed++;
    endtask

    // Write pulse of 4 low clocks, then a second pulse whose fall lands gap clocks after the rise.
    task automatic b2b(input int gap, input int want);
        clear_counts();
        csw_n_f = 1'b0;
        repeat (4) tick();
        csw_n_f = 1'b1;
        repeat (gap) tick();
        csw_n_f = 1'b0;
        repeat (4) tick();
        idle(6);
        checks++;
        if (n_wr !== want) $display("FAIL back_to_back_gap%0d: got %0d wr_stb want %0d",
                                    gap, n_wr, want);
        else passed++;
    endtask

    task automatic test_back_to_back();
        b2b(1, 1);
        b2b(2, 1);
        b2b(3, 2);
    endtask

    task automatic test_conflict();
        clear_counts();
        cd_in = 8'h5A;
        csw_n_f = 1'b0;
        repeat (3) tick();
        csr_n_f = 1'b0;
        tick();
        checks++;
        if (conflict !== 1'b1) $display("FAIL conflict_pulse: got %b want 1", conflict);
        else passed++;
        tick();
        csr_n_f = 1'b1;
        tick();
        csw_n_f = 1'b1;
        tick();
        checks++;
        if ({wr_stb, wr_data} !== {1'b1, 8'h5A})
            $display("FAIL conflict_write: got stb=%b data=%h want 1 5a", wr_stb, wr_data);
        else passed++;
        idle(5);
        checks++;
        if ({n_wr, n_rd, n_conf} !== {32'd1, 32'd0, 32'd1})
            $display("FAIL conflict_counts: got wr=%0d rd=%0d conf=%0d want 1 0 1",
                     n_wr, n_rd, n_conf);
        else passed++;
        clear_counts();
        csw_n_f = 1'b0;
        csr_n_f = 1'b0;
        tick();
        checks++;
        if (conflict !== 1'b1) $display("FAIL conflict_idle: got %b want 1", conflict);
        else passed++;
        repeat (4) tick();
        idle(4);
        checks++;
        if ({n_wr, n_rd, n_glitch, n_conf} !== {32'd0, 32'd0, 32'd0, 32'd1})
            $display("FAIL conflict_idle_counts: got wr=%0d rd=%0d gl=%0d conf=%0d want 0 0 0 1",
                     n_wr, n_rd, n_glitch, n_conf);
        else passed++;
    endtask

    task automatic test_reset_mid_read();
        clear_counts();
        rd_data = 8'h77;
        csr_n_f = 1'b0;
        repeat (5) tick();
        checks++;
        if (cd_oe !== 1'b1) $display("FAIL midread_oe_before: got %b want 1", cd_oe);
        else passed++;
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (cd_oe !== 1'b0) $display("FAIL midread_oe_async: got %b want 0", cd_oe);
        else passed++;
        tick();
        #2;
        reset_n = 1'b1;
        clear_counts();
        repeat (6) tick();
        checks++;
        if ({n_rd, n_done, cd_oe} !== {32'd0, 32'd0, 1'b0})
            $display("FAIL midread_after_release: got rd=%0d done=%0d oe=%b want 0 0 0",
                     n_rd, n_done, cd_oe);
        else passed++;
        csr_n_f = 1'b1;
        tick();
        tick();
        csr_n_f = 1'b0;
        repeat (3) tick();
        checks++;
        if (rd_stb !== 1'b1) $display("FAIL midread_new_read: got %b want 1", rd_stb);
        else passed++;
        csr_n_f = 1'b1;
        tick();
        checks++;
        if ({rd_done, cd_oe} !== 2'b10)
            $display("FAIL midread_new_done: got done/oe=%b%b want 10", rd_done, cd_oe);
        else passed++;
        idle(5);
    endtask

    task automatic test_random();
        int pos, accept, f, r, q, len, gap;
        bit is_wr;
        for (int k = 0; k < N; k++) begin
            ar_csr[k] = 1'b1;
            ar_csw[k] = 1'b1;
            ar_mode[k] = 1'($urandom_range(1, 0));
            ar_cd[k] = 8'($urandom);
            ar_rd[k] = 8'($urandom);
            ex_pulse[k] = 6'b0;
            ex_wdata[k] = 8'h00;
            ex_cd[k] = 8'h00;
            ex_wport[k] = 1'b0;
            ex_rport[k] = 1'b0;
            ex_cd_valid[k] = 1'b0;
        end
        pos = 4;
        accept = 0;
        while (pos + 20 < N) begin
            is_wr = 1'($urandom_range(1, 0));
            len = int'($urandom_range(8, 1));
            gap = int'($urandom_range(6, 1));
            f = pos;
            r = pos + len;
            for (int k = f; k < r; k++) begin
                if (is_wr) ar_csw[k] = 1'b0;
                else       ar_csr[k] = 1'b0;
            end
            if (f >= accept) begin
                if (len < int'(MIN_LOW)) begin
                    ex_pulse[r][2] = 1'b1;
                    accept = r + 1;
                end else if (is_wr) begin
                    ex_pulse[r][5] = 1'b1;
                    ex_wdata[r] = ar_cd[r-1];
                    ex_wport[r] = ar_mode[f];
                    accept = r + int'(RECOVERY) + 1;
                end else begin
                    q = f + int'(MIN_LOW) - 1;
                    ex_pulse[q][4] = 1'b1;
                    ex_rport[q] = ar_mode[f];
                    for (int k = q; k < r; k++) ex_pulse[k][0] = 1'b1;
                    for (int k = q + 1; k < r; k++) begin
                        ex_cd_valid[k] = 1'b1;
                        ex_cd[k] = ar_rd[k];
                    end
                    ex_pulse[r][3] = 1'b1;
                    accept = r + int'(RECOVERY) + 1;
                end
            end
            pos = r + gap;
        end
        for (int k = 0; k < N; k++) begin
            csr_n_f = ar_csr[k];
            csw_n_f = ar_csw[k];
            mode_f = ar_mode[k];
            cd_in = ar_cd[k];
            rd_data = ar_rd[k];
            tick();
            checks++;
            if ({wr_stb, rd_stb, rd_done, glitch, conflict, cd_oe} !== ex_pulse[k])
                $display("FAIL rand_flags_%0d: got %b want %b", k,
                         {wr_stb, rd_stb, rd_done, glitch, conflict, cd_oe}, ex_pulse[k]);
            else passed++;
            if (ex_pulse[k][5]) begin
                checks++;
                if ({wr_port, wr_data} !== {ex_wport[k], ex_wdata[k]})
                    $display("FAIL rand_write_%0d: got port=%b data=%h want %b %h", k,
                             wr_port, wr_data, ex_wport[k], ex_wdata[k]);
                else passed++;
            end
            if (ex_pulse[k][4]) begin
                checks++;
                if (rd_port !== ex_rport[k])
                    $display("FAIL rand_rd_port_%0d: got %b want %b", k, rd_port, ex_rport[k]);
                else passed++;
            end
            if (ex_cd_valid[k]) begin
                checks++;
                if (cd_out !== ex_cd[k])
                    $display("FAIL rand_cd_out_%0d: got %h want %h", k, cd_out, ex_cd[k]);
                else passed++;
            end
        end
        idle(6);
    endtask

    initial begin
        clear_counts();
        #1;
        test_reset();
        test_write();
        test_glitch();
        test_read();
        test_back_to_back();
        test_conflict();
        test_reset_mid_read();
        idle(8);
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
